// File: rtl/conv_psum_accum.sv
// Partial-sum accumulator: sums acc_len+1 signed results, rounds/shifts, buffers points in a 2-entry FIFO.
// Optional CONV_PSUM_ACCUM_SAT_EN enables output saturation; otherwise the output wraps to out_width bits.
module conv_psum_accum #(
  parameter int  in_width         = 32,
  parameter int  acc_width        = 40,
  parameter int  out_width        = 16,
  parameter int  frac_shift       = 8,
  parameter int  acc_len_width    = 8,
  parameter real simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [acc_len_width-1:0] acc_len,
  input  logic [in_width-1:0]      s_res_data,
  input  logic                     s_res_valid,
  output logic                     s_res_ready,
  output logic [out_width-1:0]     m_out_data,
  output logic                     m_out_sat,
  output logic                     m_out_valid,
  input  logic                     m_out_ready
);

  // Kept for drop-in compatibility; register updates here are zero-delay.
  localparam real unused_sim_delay = simulation_delay;

  localparam logic [acc_width:0] ONE = 1;
  localparam logic signed [acc_width:0] RND =
    (frac_shift == 0) ? {(acc_width + 1){1'b0}} : (ONE << ((frac_shift > 0) ? frac_shift - 1 : 0));

  logic [acc_len_width-1:0]    cnt;
  logic [acc_len_width-1:0]    len_lat;
  logic [acc_len_width-1:0]    len_eff;
  logic signed [acc_width-1:0] acc;
  logic signed [acc_width-1:0] elem_ext;
  logic signed [acc_width-1:0] sum_now;
  logic signed [acc_width-1:0] r_sum;
  logic signed [acc_width:0]   r_sum_x;
  logic signed [acc_width:0]   t_full;
  logic                        r_valid;
  logic                        last;
  logic                        hs;
  logic [2:0]                  occ;
  logic [out_width-1:0]        r_data;
  logic                        r_sat;

  logic [out_width:0]          mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  fifo_cnt;
  logic                        pop;

  always_comb begin
    elem_ext = acc_width'(signed'(s_res_data));
    sum_now  = (cnt == '0) ? elem_ext : acc + elem_ext;
    len_eff  = (cnt == '0) ? acc_len : len_lat;
    last     = (cnt == len_eff);
    occ      = {1'b0, fifo_cnt} + {2'b00, r_valid};
  end

  // Final elements wait for buffer room; non-final ones never do.
  assign s_res_ready = ~last | (occ <= 3'd1);
  assign hs          = s_res_valid & s_res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      len_lat <= '0;
      acc     <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      acc     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= hs & last;
      if (hs) begin
        if (cnt == '0) len_lat <= acc_len;
        acc <= sum_now;
        if (last) begin
          cnt   <= '0;
          r_sum <= sum_now;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    r_sum_x = (acc_width + 1)'(r_sum);
    t_full  = (r_sum_x + RND) >>> frac_shift;
  end

`ifdef CONV_PSUM_ACCUM_SAT_EN
  localparam logic signed [acc_width:0] O_MAX =
    {{(acc_width + 2 - out_width){1'b0}}, {(out_width - 1){1'b1}}};
  localparam logic signed [acc_width:0] O_MIN = ~O_MAX;

  always_comb begin
    r_data = t_full[out_width-1:0];
    r_sat  = 1'b0;
    if (t_full > O_MAX) begin
      r_data = {1'b0, {(out_width - 1){1'b1}}};
      r_sat  = 1'b1;
    end else if (t_full < O_MIN) begin
      r_data = {1'b1, {(out_width - 1){1'b0}}};
      r_sat  = 1'b1;
    end
  end
`else
  logic unused_t_hi;
  assign unused_t_hi = ^t_full[acc_width:out_width];
  assign r_data      = t_full[out_width-1:0];
  assign r_sat       = 1'b0;
`endif

  assign m_out_valid             = (fifo_cnt != 2'd0);
  assign pop                     = m_out_valid & m_out_ready;
  assign {m_out_data, m_out_sat} = mem[rd_ptr];

  // R always has room: the ready rule keeps fifo_cnt + r_valid <= 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else if (clear) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (r_valid) begin
        mem[wr_ptr] <= {r_data, r_sat};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({r_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed self-checking bench for conv_psum_accum; expectations follow CONV_PSUM_ACCUM_SAT_EN.
module tb_conv_psum_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  acc_len;
  logic [31:0] s_res_data;
  logic        s_res_valid;
  logic        s_res_ready;
  logic [15:0] m_out_data;
  logic        m_out_sat;
  logic        m_out_valid;
  logic        m_out_ready;

  int errors = 0;
  int checks = 0;

  logic [15:0] q_data[$];
  logic        q_sat[$];

  conv_psum_accum #(
    .in_width(32), .acc_width(40), .out_width(16), .frac_shift(8), .acc_len_width(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .acc_len(acc_len),
    .s_res_data(s_res_data), .s_res_valid(s_res_valid), .s_res_ready(s_res_ready),
    .m_out_data(m_out_data), .m_out_sat(m_out_sat), .m_out_valid(m_out_valid),
    .m_out_ready(m_out_ready)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees exactly what the next edge consumes.
  always @(negedge clk) begin
    if (m_out_valid && m_out_ready) begin
      q_data.push_back(m_out_data);
      q_sat.push_back(m_out_sat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    int  n;
    bit  ok;
    n = 0;
    ok = 1'b0;
    s_res_data  = d;
    s_res_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_res_ready;
      step();
      n++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: data=%0d not accepted within %0d cycles", $signed(d), n);
    end
  endtask

  task automatic test_reset();
    if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_out_valid); end
    checks++;
    if (m_out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", m_out_data); end
    checks++;
    if (m_out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", m_out_sat); end
    checks++;
    if (s_res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_res_ready); end
    checks++;
  endtask

  task automatic test_single();
    q_data.delete(); q_sat.delete();
    acc_len = 8'd0;
    push(32'sd384);
    s_res_valid = 1'b0;
    @(negedge clk);
    if (m_out_valid !== 1'b0) begin errors++; $display("FAIL single_lat_early: valid=%b want 0", m_out_valid); end
    checks++;
    @(negedge clk);
    if (m_out_valid !== 1'b1) begin errors++; $display("FAIL single_lat_valid: valid=%b want 1", m_out_valid); end
    checks++;
    if (m_out_data !== 16'd2) begin errors++; $display("FAIL single_data: got %0d want 2", $signed(m_out_data)); end
    checks++;
    if (m_out_sat !== 1'b0) begin errors++; $display("FAIL single_sat: got %b want 0", m_out_sat); end
    checks++;
    step();
    push(-32'sd384);
    s_res_valid = 1'b0;
    repeat (4) step();
    if (q_data.size() !== 2) begin errors++; $display("FAIL single_count: got %0d want 2", q_data.size()); end
    else if (q_data[1] !== 16'hFFFF) begin errors++; $display("FAIL single_neg: got %0d want -1", $signed(q_data[1])); end
    checks++;
  endtask

  task automatic test_multi();
    q_data.delete(); q_sat.delete();
    acc_len = 8'd3;
    push(32'sd100);
    acc_len = 8'd0;
    push(32'sd200);
    push(-32'sd50);
    push(32'sd6);
    s_res_valid = 1'b0;
    repeat (5) step();
    if (q_data.size() !== 1) begin errors++; $display("FAIL multi_count: got %0d want 1", q_data.size()); end
    else if (q_data[0] !== 16'd1) begin errors++; $display("FAIL multi_data: got %0d want 1", $signed(q_data[0])); end
    checks++;
  endtask

  task automatic test_sat();
    logic [15:0] exp_pos, exp_neg;
    logic        exp_s;
`ifdef CONV_PSUM_ACCUM_SAT_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000; exp_s = 1'b1;
`else
    exp_pos = 16'h0000; exp_neg = 16'h676A; exp_s = 1'b0;
`endif
    q_data.delete(); q_sat.delete();
    acc_len = 8'd1;
    push(32'h7FFF_FFFF);
    push(32'h7FFF_FFFF);
    acc_len = 8'd0;
    push(-32'sd10000000);
    s_res_valid = 1'b0;
    repeat (5) step();
    if (q_data.size() !== 2) begin
      errors++; $display("FAIL sat_count: got %0d want 2", q_data.size());
    end else begin
      if (q_data[0] !== exp_pos) begin errors++; $display("FAIL sat_pos_data: got %h want %h", q_data[0], exp_pos); end
      checks++;
      if (q_sat[0] !== exp_s) begin errors++; $display("FAIL sat_pos_flag: got %b want %b", q_sat[0], exp_s); end
      checks++;
      if (q_data[1] !== exp_neg) begin errors++; $display("FAIL sat_neg_data: got %h want %h", q_data[1], exp_neg); end
      checks++;
      if (q_sat[1] !== exp_s) begin errors++; $display("FAIL sat_neg_flag: got %b want %b", q_sat[1], exp_s); end
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int  n_acc;
    bit  rdy;
    q_data.delete(); q_sat.delete();
    m_out_ready = 1'b0;
    acc_len     = 8'd0;
    n_acc       = 0;
    s_res_valid = 1'b1;
    s_res_data  = 32'sd256;
    repeat (6) begin
      @(negedge clk);
      rdy = s_res_ready;
      step();
      if (rdy) begin
        n_acc++;
        s_res_data = 32'(256 * (n_acc + 1));
      end
    end
    if (n_acc !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", n_acc); end
    checks++;
    if (s_res_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: ready=%b want 0", s_res_ready); end
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 16'd1) begin
      errors++; $display("FAIL bp_head: valid=%b data=%0d want valid=1 data=1", m_out_valid, m_out_data);
    end
    checks++;
    m_out_ready = 1'b1;
    push(32'sd768);
    push(32'sd1024);
    s_res_valid = 1'b0;
    repeat (8) step();
    if (q_data.size() !== 4) begin
      errors++; $display("FAIL bp_count: got %0d want 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q_data[i] !== 16'(i + 1)) begin
          errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, q_data[i], i + 1);
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_clear();
    q_data.delete(); q_sat.delete();
    acc_len = 8'd3;
    push(32'sd1000);
    push(32'sd2000);
    s_res_data  = 32'sd3000;
    clear       = 1'b1;
    step();
    clear       = 1'b0;
    s_res_valid = 1'b0;
    repeat (4) step();
    if (q_data.size() !== 0) begin errors++; $display("FAIL clear_no_output: got %0d points want 0", q_data.size()); end
    checks++;
    push(32'sd1);
    push(32'sd1);
    push(32'sd1);
    push(32'sd1);
    s_res_valid = 1'b0;
    repeat (5) step();
    if (q_data.size() !== 1) begin errors++; $display("FAIL clear_next_count: got %0d want 1", q_data.size()); end
    else if (q_data[0] !== 16'd0) begin errors++; $display("FAIL clear_next_data: got %0d want 0", $signed(q_data[0])); end
    checks++;
  endtask

  task automatic test_reset_mid();
    m_out_ready = 1'b0;
    acc_len     = 8'd0;
    push(32'sd256);
    push(32'sd512);
    acc_len = 8'd3;
    push(32'sd100);
    s_res_valid = 1'b0;
    step();
    if (m_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b want 1", m_out_valid); end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (m_out_valid !== 1'b0 || m_out_data !== 16'h0000 || m_out_sat !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b data=%h sat=%b want 0/0000/0", m_out_valid, m_out_data, m_out_sat);
    end
    checks++;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    if (s_res_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", s_res_ready); end
    checks++;
    q_data.delete(); q_sat.delete();
    m_out_ready = 1'b1;
    acc_len     = 8'd0;
    push(32'sd256);
    s_res_valid = 1'b0;
    repeat (5) step();
    if (q_data.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", q_data.size()); end
    else if (q_data[0] !== 16'd1) begin errors++; $display("FAIL rstmid_data: got %0d want 1", $signed(q_data[0])); end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    acc_len     = 8'd0;
    s_res_data  = '0;
    s_res_valid = 1'b0;
    m_out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_single();
    test_multi();
    test_sat();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
